// File: rtl/board_io_ctrl.sv
// -----------------------------------------------------------------------------
// board_io_ctrl
//
// Conditions the raw board pins (buttons, switches, LEDs) on the way to and
// from the SoC GPIO bus.
//
//   Input path  : per channel, 2-flop synchroniser -> debounce counter ->
//                 registered level (din_o) plus one-cycle rise/fall pulses.
//   Output path : per channel, LED drive in direct, PWM-dimmed or blink mode,
//                 using one shared PWM counter and one shared blink prescaler.
//
// Ports
//   clk          system clock
//   rst_n        asynchronous active-low reset, clears every flop
//   raw_in_i     [N_IN]            asynchronous board inputs
//   din_o        [N_IN]            debounced input levels
//   rise_o       [N_IN]            one-cycle pulse on an accepted 0->1 change
//   fall_o       [N_IN]            one-cycle pulse on an accepted 1->0 change
//   event_o      1                 OR of all rise/fall bits
//   led_dout_i   [N_OUT]           LED request per channel (clk-synchronous)
//   led_mode_i   [2*N_OUT]         channel i mode in bits [2i+1:2i]
//                                  00 direct, 01 PWM, 10 blink, 11 off
//   led_duty_i   [PWM_WIDTH*N_OUT] channel i duty in [PWM_WIDTH*i +: PWM_WIDTH]
//   led_out_o    [N_OUT]           registered LED pin drive
// -----------------------------------------------------------------------------
module board_io_ctrl #(
    parameter int N_IN            = 4,
    parameter int N_OUT           = 4,
    parameter int DEBOUNCE_CYCLES = 100000,
    parameter int PWM_WIDTH       = 8,
    parameter int BLINK_DIV       = 50000000
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [N_IN-1:0]              raw_in_i,
    output logic [N_IN-1:0]              din_o,
    output logic [N_IN-1:0]              rise_o,
    output logic [N_IN-1:0]              fall_o,
    output logic                         event_o,
    input  logic [N_OUT-1:0]             led_dout_i,
    input  logic [2*N_OUT-1:0]           led_mode_i,
    input  logic [PWM_WIDTH*N_OUT-1:0]   led_duty_i,
    output logic [N_OUT-1:0]             led_out_o
);

    // -------------------------------------------------------------------------
    // Local constants
    // -------------------------------------------------------------------------
    localparam int CNT_W   = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int BLINK_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

    // Counter value on the edge that accepts a change: the mismatch has then
    // been seen on DEBOUNCE_CYCLES consecutive edges including this one.
    localparam logic [CNT_W-1:0]   CNT_LAST   = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_DIV - 1);

    typedef enum logic [1:0] {
        MODE_DIRECT = 2'b00,
        MODE_PWM    = 2'b01,
        MODE_BLINK  = 2'b10,
        MODE_RSVD   = 2'b11
    } led_mode_t;

    // -------------------------------------------------------------------------
    // Input path: one independent synchroniser + debouncer per channel
    // -------------------------------------------------------------------------
    genvar gi;
    generate
        for (gi = 0; gi < N_IN; gi++) begin : g_in
            logic             s1_q;
            logic             s2_q;
            logic             din_q,  din_d;
            logic             rise_q, rise_d;
            logic             fall_q, fall_d;
            logic [CNT_W-1:0] cnt_q,  cnt_d;

            always_comb begin
                cnt_d  = cnt_q;
                din_d  = din_q;
                rise_d = 1'b0;
                fall_d = 1'b0;
                if (s2_q == din_q) begin
                    // Any agreement restarts the stability window, so a
                    // glitch shorter than the window leaves no trace.
                    cnt_d = '0;
                end else if (cnt_q == CNT_LAST) begin
                    din_d  = s2_q;
                    cnt_d  = '0;
                    rise_d = s2_q;
                    fall_d = ~s2_q;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    s1_q   <= 1'b0;
                    s2_q   <= 1'b0;
                    din_q  <= 1'b0;
                    rise_q <= 1'b0;
                    fall_q <= 1'b0;
                    cnt_q  <= '0;
                end else begin
                    s1_q   <= raw_in_i[gi];
                    s2_q   <= s1_q;
                    din_q  <= din_d;
                    rise_q <= rise_d;
                    fall_q <= fall_d;
                    cnt_q  <= cnt_d;
                end
            end

            assign din_o[gi]  = din_q;
            assign rise_o[gi] = rise_q;
            assign fall_o[gi] = fall_q;
        end
    endgenerate

    // Built from registered pulses only, so it is glitch-free for GPIO use.
    assign event_o = |(rise_o | fall_o);

    // -------------------------------------------------------------------------
    // Output path: shared PWM counter and blink timebase
    // -------------------------------------------------------------------------
    logic [PWM_WIDTH-1:0] pwm_cnt_q, pwm_cnt_d;
    logic [BLINK_W-1:0]   presc_q,   presc_d;
    logic                 blink_phase_q, blink_phase_d;

    always_comb begin
        // Free-running; the natural wrap gives the 2^PWM_WIDTH period.
        pwm_cnt_d     = pwm_cnt_q + PWM_WIDTH'(1);
        presc_d       = presc_q + BLINK_W'(1);
        blink_phase_d = blink_phase_q;
        if (presc_q == BLINK_LAST) begin
            presc_d       = '0;
            blink_phase_d = ~blink_phase_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pwm_cnt_q     <= '0;
            presc_q       <= '0;
            blink_phase_q <= 1'b0;
        end else begin
            pwm_cnt_q     <= pwm_cnt_d;
            presc_q       <= presc_d;
            blink_phase_q <= blink_phase_d;
        end
    end

    // -------------------------------------------------------------------------
    // Per-channel LED mode mux, registered at the pin
    // -------------------------------------------------------------------------
    generate
        for (gi = 0; gi < N_OUT; gi++) begin : g_out
            led_mode_t            mode;
            logic [PWM_WIDTH-1:0] duty;
            logic                 pwm_on;
            logic                 led_q, led_d;

            assign mode   = led_mode_t'(led_mode_i[2*gi +: 2]);
            assign duty   = led_duty_i[PWM_WIDTH*gi +: PWM_WIDTH];
            // Strict compare: duty 0 never lights, full-scale duty leaves
            // exactly one dark count per period.
            assign pwm_on = (pwm_cnt_q < duty);

            always_comb begin
                led_d = 1'b0;
                case (mode)
                    MODE_DIRECT: led_d = led_dout_i[gi];
                    MODE_PWM:    led_d = led_dout_i[gi] & pwm_on;
                    MODE_BLINK:  led_d = led_dout_i[gi] & blink_phase_q;
                    default:     led_d = 1'b0;
                endcase
            end

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    led_q <= 1'b0;
                end else begin
                    led_q <= led_d;
                end
            end

            assign led_out_o[gi] = led_q;
        end
    endgenerate

endmodule

// File: tb/tb_board_io_ctrl.sv
// -----------------------------------------------------------------------------
// Testbench for board_io_ctrl (DEBOUNCE_CYCLES=4, PWM_WIDTH=4, BLINK_DIV=8,
// N_IN=N_OUT=4).
//
// A reference model runs on every rising edge and pushes the expected outputs
// for that cycle into a scoreboard queue; accepted input changes are also
// pushed into an event queue. A monitor on the falling edge pops and compares.
// The model works from the behavioural rules: the input seen by the debouncer
// is the raw input two edges old, a change is accepted once the last
// DEBOUNCE_CYCLES seen values all differ from the current level, and the LED
// timebases are derived from the number of edges since reset.
// -----------------------------------------------------------------------------
module tb_board_io_ctrl;

    localparam int N_IN = 4;
    localparam int N_OUT = 4;
    localparam int DEB = 4;
    localparam int PW = 4;
    localparam int BD = 8;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic [N_IN-1:0]  raw_in = '0;
    logic [N_IN-1:0]  din, rise, fall;
    logic             ev;
    logic [N_OUT-1:0] led_dout = '0;
    logic [2*N_OUT-1:0]  led_mode = '0;
    logic [PW*N_OUT-1:0] led_duty = '0;
    logic [N_OUT-1:0] led_out;

    always #5 clk = ~clk;

    board_io_ctrl #(
        .N_IN(N_IN), .N_OUT(N_OUT), .DEBOUNCE_CYCLES(DEB),
        .PWM_WIDTH(PW), .BLINK_DIV(BD)
    ) dut (
        .clk(clk), .rst_n(rst_n), .raw_in_i(raw_in), .din_o(din),
        .rise_o(rise), .fall_o(fall), .event_o(ev), .led_dout_i(led_dout),
        .led_mode_i(led_mode), .led_duty_i(led_duty), .led_out_o(led_out)
    );

    typedef struct {
        logic [3:0] din;
        logic [3:0] rise;
        logic [3:0] fall;
        logic [3:0] led;
    } cyc_t;

    typedef struct {
        int         cyc;
        logic [3:0] rise;
        logic [3:0] fall;
    } evt_t;

    cyc_t exp_q[$];
    evt_t evt_q[$];
    int   checks = 0;
    int   errors = 0;

    // ---------------- reference model state ----------------
    int         n_edge = 0;       // edges since reset release
    logic [3:0] raw_d1 = '0;      // raw input sampled one edge ago
    logic [3:0] raw_d2 = '0;      // raw input sampled two edges ago
    logic [3:0] din_m = '0;
    logic [3:0] seen_hist[$];     // last DEB values seen by the debouncer

    task automatic model_step();
        cyc_t       c;
        evt_t       e;
        logic [3:0] seen;
        bit         all_diff;
        int         duty;
        bit         pwm_on, phase;
        c = '{default: '0};
        if (!rst_n) begin
            n_edge = 0; raw_d1 = '0; raw_d2 = '0; din_m = '0;
            seen_hist.delete();
            exp_q.push_back(c);
            return;
        end
        seen   = raw_d2;
        raw_d2 = raw_d1;
        raw_d1 = raw_in;
        seen_hist.push_back(seen);
        if (seen_hist.size() > DEB) void'(seen_hist.pop_front());
        for (int i = 0; i < N_IN; i++) begin
            if (seen_hist.size() == DEB) begin
                all_diff = 1'b1;
                for (int k = 0; k < DEB; k++)
                    if (seen_hist[k][i] == din_m[i]) all_diff = 1'b0;
                if (all_diff) begin
                    din_m[i] = ~din_m[i];
                    if (din_m[i]) c.rise[i] = 1'b1;
                    else          c.fall[i] = 1'b1;
                end
            end
        end
        c.din = din_m;
        pwm_on = 1'b0;
        phase  = (((n_edge / BD) % 2) == 1);
        for (int i = 0; i < N_OUT; i++) begin
            duty   = int'(led_duty[PW*i +: PW]);
            pwm_on = ((n_edge % (1 << PW)) < duty);
            case (led_mode[2*i +: 2])
                2'b00:   c.led[i] = led_dout[i];
                2'b01:   c.led[i] = led_dout[i] & pwm_on;
                2'b10:   c.led[i] = led_dout[i] & phase;
                default: c.led[i] = 1'b0;
            endcase
        end
        if ((c.rise | c.fall) != 4'h0) begin
            e.cyc  = n_edge;
            e.rise = c.rise;
            e.fall = c.fall;
            evt_q.push_back(e);
        end
        exp_q.push_back(c);
        n_edge++;
    endtask

    initial forever begin
        @(posedge clk);
        model_step();
    end

    // ---------------- monitor / scoreboard ----------------
    task automatic chk(input string name, input logic [3:0] act, input logic [3:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic monitor_step();
        cyc_t c;
        evt_t e;
        if (exp_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL scoreboard_empty: got no expected entry at t=%0t", $time);
            return;
        end
        c = exp_q.pop_front();
        if (!rst_n) begin
            // Reset clears everything asynchronously, whatever the last edge did.
            c = '{default: '0};
            evt_q.delete();
        end
        chk("din",     din,     c.din);
        chk("rise",    rise,    c.rise);
        chk("fall",    fall,    c.fall);
        chk("led_out", led_out, c.led);
        chk("event",   {3'b000, ev}, {3'b000, |(c.rise | c.fall)});
        if (ev && rst_n) begin
            if (evt_q.size() == 0) begin
                checks++; errors++;
                $display("FAIL unexpected_event: got rise=%b fall=%b expected none at t=%0t",
                         rise, fall, $time);
            end else begin
                e = evt_q.pop_front();
                chk("evt_rise", rise, e.rise);
                chk("evt_fall", fall, e.fall);
                $display("event cycle=%0d rise=%b fall=%b din=%b", e.cyc, rise, fall, din);
            end
        end
    endtask

    initial forever begin
        @(negedge clk);
        monitor_step();
    end

    // ---------------- stimulus ----------------
    task automatic step(input int k);
        repeat (k) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic pulse_reset(input int k);
        @(posedge clk);
        #2 rst_n = 1'b0;      // mid-cycle: the next falling-edge check sees it
        step(k);
        rst_n = 1'b1;
    endtask

    initial begin
        step(3);
        rst_n = 1'b1;

        // Clean press and release on channel 0
        raw_in[0] = 1'b1; step(20);
        raw_in[0] = 1'b0; step(20);

        // Bounce on channel 1: 3-cycle highs separated by single lows
        raw_in[1] = 1'b1; step(3);
        raw_in[1] = 1'b0; step(1);
        raw_in[1] = 1'b1; step(3);
        raw_in[1] = 1'b0; step(1);
        raw_in[1] = 1'b1; step(20);

        // Simultaneous change on channels 3 and 2
        raw_in[3:2] = 2'b11; step(20);

        // LED modes: ch0 PWM, ch1 blink, ch2 reserved, ch3 direct
        led_mode = 8'b00_11_10_01;
        led_dout = 4'hF;
        led_duty = 16'h0004;
        for (int i = 0; i < 40; i++) begin
            led_dout[3] = 1'($urandom_range(0, 1));
            step(1);
        end
        led_duty = 16'h0000; step(20);
        led_duty = 16'h000F; step(40);

        // Reset mid-operation with all inputs high, then re-acceptance
        raw_in = 4'hF;
        step(10);
        pulse_reset(3);
        step(20);

        // Randomised phase
        for (int i = 0; i < 2500; i++) begin
            for (int b = 0; b < N_IN; b++)
                if ($urandom_range(0, 5) == 0) raw_in[b] = ~raw_in[b];
            if ($urandom_range(0, 15) == 0) begin
                led_mode = 8'($urandom);
                led_duty = 16'($urandom);
                led_dout = 4'($urandom);
            end
            if ($urandom_range(0, 499) == 0) pulse_reset(2);
            else step(1);
        end

        step(4);
        checks++;
        if (evt_q.size() != 0) begin
            errors++;
            $display("FAIL leftover_events: got %0d pending expected 0", evt_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
